phase_timer: RTL



---
 rtl/game_pkg.sv | 34 +++
 rtl/bcd_split_99.sv | 34 +++
 rtl/phase_timer.sv | 161 ++++++++++++++++
 3 files changed

// File: rtl/game_pkg.sv
// Shared game-state definitions for the main controller and the phase timer.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package game_pkg;

    // Main controller state encoding, shared by every block that decodes it.
    typedef enum logic [2:0] {
        GS_IDLE    = 3'd0,
        GS_PHASE1  = 3'd1,
        GS_PHASE2  = 3'd2,
        GS_PHASE3  = 3'd3,
        GS_PHASE4  = 3'd4,
        GS_SUCCESS = 3'd5,
        GS_FAIL    = 3'd6
    } game_state_t;

    // Width of a seconds value (0..99).
    localparam int SEC_W = 7;

    // Width of the signed working value for seconds arithmetic. It spans
    // -4..104 in practice, so 9 signed bits leave comfortable headroom.
    localparam int SEC_CALC_W = 9;

    // True for the four timed puzzle phases.
    function automatic logic is_phase(input logic [2:0] st);
        return (st >= GS_PHASE1) && (st <= GS_PHASE4);
    endfunction

    // Encodings 0..6 are defined; 7 is treated as a non-running state.
    function automatic logic is_valid_state(input logic [2:0] st);
        return st <= GS_FAIL;
    endfunction

endpackage

// File: rtl/bcd_split_99.sv
// Combinational 7-bit binary to two-digit BCD split for the 7-segment path.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; inputs above 99 saturate to 9/9.
//
// Ports:
//   bin  in  7 : binary value, nominally 0..99
//   tens out 4 : BCD tens digit
//   ones out 4 : BCD ones digit
module bcd_split_99 (
    input  logic [6:0] bin,
    output logic [3:0] tens,
    output logic [3:0] ones
);

    // Compare against each multiple of ten rather than dividing; the last
    // threshold passed gives the tens digit and the remainder the ones digit.
    always_comb begin
        tens = 4'd0;
        ones = 4'd0;
        if (bin > 7'd99) begin
            tens = 4'd9;
            ones = 4'd9;
        end else begin
            ones = 4'(bin);
            for (int d = 1; d <= 9; d++) begin
                if (bin >= 7'(d * 10)) begin
                    tens = 4'(d);
                    ones = 4'(bin - 7'(d * 10));
                end
            end
        end
    end

endmodule

// File: rtl/phase_timer.sv
// Per-phase countdown timer with puzzle bonus/penalty handling and BCD display output.
// Latency: phase load visible 1 cycle after state change; input edges applied 1 cycle after rise.
// Backpressure: none; freezes whenever game_enable is low or time_out is set.
//
// Ports:
//   clk            in  1 : system clock
//   rst            in  1 : synchronous active-high reset
//   current_state  in  3 : main controller state (game_state_t encoding)
//   game_enable    in  1 : high while in PHASE1..4
//   timer_reset    in  1 : high while in IDLE
//   puzzle_correct in  1 : level, rising edge grants BONUS_SEC
//   puzzle_fail    in  1 : level, rising edge costs PENALTY_SEC
//   event_fail     in  1 : level, rising edge costs PENALTY_SEC
//   time_out       out 1 : registered, set when the countdown reaches 0
//   tick_1hz       out 1 : one-cycle pulse after each prescaler wrap
//   sec_remaining  out 7 : registered seconds left, 0..MAX_SEC
//   sec_tens       out 4 : BCD tens digit of sec_remaining
//   sec_ones       out 4 : BCD ones digit of sec_remaining
//   warn           out 1 : 0 < sec_remaining <= 10 while game_enable is high
module phase_timer
    import game_pkg::*;
#(
    parameter int TICK_DIV    = 50_000_000,
    parameter int PHASE1_SEC  = 60,
    parameter int PHASE2_SEC  = 50,
    parameter int PHASE3_SEC  = 40,
    parameter int PHASE4_SEC  = 30,
    parameter int BONUS_SEC   = 5,
    parameter int PENALTY_SEC = 3,
    parameter int MAX_SEC     = 99
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] current_state,
    input  logic       game_enable,
    input  logic       timer_reset,
    input  logic       puzzle_correct,
    input  logic       puzzle_fail,
    input  logic       event_fail,
    output logic       time_out,
    output logic       tick_1hz,
    output logic [6:0] sec_remaining,
    output logic [3:0] sec_tens,
    output logic [3:0] sec_ones,
    output logic       warn
);

    localparam int PS_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [PS_W-1:0] PS_LAST = PS_W'(TICK_DIV - 1);

    localparam logic signed [SEC_CALC_W-1:0] BONUS_S   = SEC_CALC_W'(BONUS_SEC);
    localparam logic signed [SEC_CALC_W-1:0] PENALTY_S = SEC_CALC_W'(PENALTY_SEC);
    localparam logic signed [SEC_CALC_W-1:0] MAX_S     = SEC_CALC_W'(MAX_SEC);
    localparam logic        [SEC_W-1:0]      MAX_U     = SEC_W'(MAX_SEC);

    // Seconds loaded on entry to each phase; non-phase states map to 0.
    function automatic logic [SEC_W-1:0] phase_secs(input logic [2:0] st);
        case (st)
            GS_PHASE1: return SEC_W'(PHASE1_SEC);
            GS_PHASE2: return SEC_W'(PHASE2_SEC);
            GS_PHASE3: return SEC_W'(PHASE3_SEC);
            GS_PHASE4: return SEC_W'(PHASE4_SEC);
            default:   return '0;
        endcase
    endfunction

    logic [PS_W-1:0] prescaler;
    logic [2:0]      prev_state;
    logic            corr_q;
    logic            pfail_q;
    logic            efail_q;

    logic            corr_edge;
    logic            fail_edge;
    logic            phase_entry;
    logic            run;
    logic            tick;

    logic signed [SEC_CALC_W-1:0] sec_sum;
    logic        [SEC_W-1:0]      sec_next;

    // Rising-edge detection against the one-cycle-old copy of each input.
    // Both fail sources collapse into a single penalty.
    assign corr_edge = puzzle_correct & ~corr_q;
    assign fail_edge = (puzzle_fail & ~pfail_q) | (event_fail & ~efail_q);

    assign phase_entry = (current_state != prev_state) && is_phase(current_state);
    assign run         = game_enable && is_valid_state(current_state) && !time_out;
    assign tick        = (prescaler == PS_LAST);

    // Tick, bonus and penalty from the same cycle all contribute. The sum is
    // formed signed so an underflow can be clamped to zero instead of wrapping.
    always_comb begin
        sec_sum = $signed({2'b00, sec_remaining});
        if (tick) begin
            sec_sum = sec_sum - SEC_CALC_W'(1);
        end
        if (corr_edge) begin
            sec_sum = sec_sum + BONUS_S;
        end
        if (fail_edge) begin
            sec_sum = sec_sum - PENALTY_S;
        end

        if (sec_sum < $signed(SEC_CALC_W'(0))) begin
            sec_next = '0;
        end else if (sec_sum > MAX_S) begin
            sec_next = MAX_U;
        end else begin
            sec_next = sec_sum[SEC_W-1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sec_remaining <= '0;
            time_out      <= 1'b0;
            tick_1hz      <= 1'b0;
            prescaler     <= '0;
            prev_state    <= GS_IDLE;
            corr_q        <= 1'b0;
            pfail_q       <= 1'b0;
            efail_q       <= 1'b0;
        end else begin
            // History registers track the inputs every cycle, so an edge
            // swallowed by a reset or a load is not replayed later.
            prev_state <= current_state;
            corr_q     <= puzzle_correct;
            pfail_q    <= puzzle_fail;
            efail_q    <= event_fail;
            tick_1hz   <= 1'b0;

            if (timer_reset) begin
                sec_remaining <= '0;
                time_out      <= 1'b0;
                prescaler     <= '0;
            end else if (phase_entry) begin
                // Edges and ticks in the load cycle are deliberately dropped.
                sec_remaining <= phase_secs(current_state);
                time_out      <= 1'b0;
                prescaler     <= '0;
            end else if (run) begin
                prescaler     <= tick ? '0 : prescaler + PS_W'(1);
                tick_1hz      <= tick;
                sec_remaining <= sec_next;
                if (sec_next == '0) begin
                    time_out <= 1'b1;
                end
            end
        end
    end

    bcd_split_99 u_bcd (
        .bin  (sec_remaining),
        .tens (sec_tens),
        .ones (sec_ones)
    );

    assign warn = game_enable && (sec_remaining != '0) && (sec_remaining <= 7'd10);

endmodule
